// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_t;

   localparam int unsigned VEC_COUNT = 16;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned ERR_W     = 5;

   // Expected F for F = PI M(0,1,2,8,10,12,14): bit i is F(ABCD = i).
   localparam logic [VEC_COUNT-1:0] MASK_PIM_0_1_2_8_10_12_14 = 16'hAAF8;

   function automatic logic expect_bit(input logic [VEC_COUNT-1:0] mask,
                                       input logic [IDX_W-1:0]     idx);
      return mask[idx];
   endfunction

endpackage

// File: rtl/sweep_sync.sv
// Two-flop synchronizer for the function-under-test response (used with SWEEP_SYNC_EN).
module sweep_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic d_out
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   // Next-value selection for both stages.
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q;

endmodule

// File: rtl/sweep_checker.sv
// Sweeps ABCD = 0..15 into a 4-input function and scores f_in against EXPECT_MASK.
// Optional SWEEP_SYNC_EN inserts a 2-flop synchronizer on f_in and stretches the hold.
module sweep_checker
   import sweep_pkg::*;
#(
   parameter logic [VEC_COUNT-1:0] EXPECT_MASK = MASK_PIM_0_1_2_8_10_12_14,
   parameter int unsigned          SETTLE      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             f_in,
   output logic [IDX_W-1:0] abcd,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             err_valid,
   output logic [IDX_W-1:0] first_err_idx
);

   logic f_cmp_s;

`ifdef SWEEP_SYNC_EN
   // Two extra hold cycles absorb the synchronizer latency.
   localparam logic [4:0] SETTLE_LAST = 5'(SETTLE + 1);

   sweep_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .d_in  (f_in),
      .d_out (f_cmp_s)
   );
`else
   localparam logic [4:0] SETTLE_LAST = 5'(SETTLE - 1);

   assign f_cmp_s = f_in;
`endif

   sweep_state_t     state_d, state_q;
   logic [IDX_W-1:0] idx_d, idx_q;
   logic [4:0]       cnt_d, cnt_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;
   logic             pass_d, pass_q;
   logic [ERR_W-1:0] err_count_d, err_count_q;
   logic             err_valid_d, err_valid_q;
   logic [IDX_W-1:0] first_err_idx_d, first_err_idx_q;
   logic             mismatch_s;

   assign mismatch_s = (f_cmp_s != expect_bit(EXPECT_MASK, idx_q));

   // Sweep sequencing and result accumulation.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      cnt_d           = cnt_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      pass_d          = pass_q;
      err_count_d     = err_count_q;
      err_valid_d     = err_valid_q;
      first_err_idx_d = first_err_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d         = ST_SETTLE;
               idx_d           = {IDX_W{1'b0}};
               cnt_d           = 5'd0;
               busy_d          = 1'b1;
               pass_d          = 1'b0;
               err_count_d     = {ERR_W{1'b0}};
               err_valid_d     = 1'b0;
               first_err_idx_d = {IDX_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_SAMPLE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_SAMPLE: begin
            if (mismatch_s) begin
               err_count_d = err_count_q + 5'd1;
               if (!err_valid_q) begin
                  err_valid_d     = 1'b1;
                  first_err_idx_d = idx_q;
               end else begin
                  err_valid_d = 1'b1;
               end
            end else begin
               err_count_d = err_count_q;
            end
            // The final compare is folded into pass on the same edge that enters DONE.
            if (idx_q == 4'd15) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (err_count_d == {ERR_W{1'b0}});
            end else begin
               state_d = ST_SETTLE;
               idx_d   = idx_q + 4'd1;
               cnt_d   = 5'd0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         idx_q           <= {IDX_W{1'b0}};
         cnt_q           <= 5'd0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_count_q     <= {ERR_W{1'b0}};
         err_valid_q     <= 1'b0;
         first_err_idx_q <= {IDX_W{1'b0}};
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         cnt_q           <= cnt_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
         err_count_q     <= err_count_d;
         err_valid_q     <= err_valid_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign abcd          = idx_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_count_q;
   assign err_valid     = err_valid_q;
   assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_sweep_checker.sv
// Self-checking bench for sweep_checker: truth-table responder plus result model.
module tb_sweep_checker;

`ifdef SWEEP_SYNC_EN
   localparam int PER = 5;
`else
   localparam int PER = 3;
`endif
   localparam int LAT = 16 * PER;

   logic       clk;
   logic       rst;
   logic       start;
   logic       f_in;
   logic [3:0] abcd;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_count;
   logic       err_valid;
   logic [3:0] first_err_idx;

   int tests;
   int failed;

   // Function under test: a lookup table the bench rewrites per sweep.
   logic resp [16];
   // Golden truth table built from the maxterm list.
   logic gold [16];

   sweep_checker dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .f_in          (f_in),
      .abcd          (abcd),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .err_valid     (err_valid),
      .first_err_idx (first_err_idx)
   );

   assign f_in = resp[abcd];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".abcd"},          abcd, 0);
      check({tag, ".busy"},          busy, 0);
      check({tag, ".done"},          done, 0);
      check({tag, ".pass"},          pass, 0);
      check({tag, ".err_count"},     err_count, 0);
      check({tag, ".err_valid"},     err_valid, 0);
      check({tag, ".first_err_idx"}, first_err_idx, 0);
   endtask

   // One full sweep; start is re-pulsed at step restart_at (negative = never).
   task automatic run_sweep(input string tag, input int restart_at);
      int exp_errs;
      int exp_first;
      int k;
      int abcd_bad;
      exp_errs  = 0;
      exp_first = 0;
      for (int i = 15; i >= 0; i--) begin
         if (resp[i] !== gold[i]) begin
            exp_errs++;
            exp_first = i;
         end
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, ".busy_after_start"}, busy, 1);
      k = 0;
      abcd_bad = 0;
      while (done !== 1'b1 && k < LAT + 20) begin
         if (abcd !== 4'(k / PER)) abcd_bad++;
         start = (k == restart_at);
         @(posedge clk);
         #1;
         k++;
      end
      start = 1'b0;
      check({tag, ".done_cycle"},    k, LAT);
      check({tag, ".abcd_trace"},    abcd_bad, 0);
      check({tag, ".busy_at_done"},  busy, 0);
      check({tag, ".pass"},          pass, (exp_errs == 0) ? 1 : 0);
      check({tag, ".err_count"},     err_count, exp_errs);
      check({tag, ".err_valid"},     err_valid, (exp_errs != 0) ? 1 : 0);
      check({tag, ".first_err_idx"}, first_err_idx, exp_first);
      @(posedge clk);
      #1;
      check({tag, ".done_one_cycle"}, done, 0);
      check({tag, ".held_err_count"}, err_count, exp_errs);
      check({tag, ".held_pass"},      pass, (exp_errs == 0) ? 1 : 0);
   endtask

   task automatic load_golden();
      for (int i = 0; i < 16; i++) resp[i] = gold[i];
   endtask

   initial begin
      int maxterms [7];
      int n;
      maxterms = '{0, 1, 2, 8, 10, 12, 14};
      tests  = 0;
      failed = 0;
      for (int i = 0; i < 16; i++) begin
         gold[i] = 1'b1;
         for (int j = 0; j < 7; j++) if (maxterms[j] == i) gold[i] = 1'b0;
      end
      load_golden();

      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_busy", busy, 0);

      run_sweep("golden", -1);

      for (int i = 0; i < 16; i++) resp[i] = 1'b0;
      run_sweep("tie0", -1);
      check("tie0_const_errs", err_count, 9);
      check("tie0_const_first", first_err_idx, 3);

      for (int i = 0; i < 16; i++) resp[i] = 1'b1;
      run_sweep("tie1", -1);
      check("tie1_const_errs", err_count, 7);
      check("tie1_const_first", first_err_idx, 0);

      load_golden();
      run_sweep("restart_golden", 10);
      for (int i = 0; i < 16; i++) resp[i] = 1'b0;
      run_sweep("restart_tie0", 10);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) resp[i] = 1'($urandom_range(0, 1));
         run_sweep("random", (r == 2) ? int'($urandom_range(1, LAT - 2)) : -1);
      end

      // Single-vector fault at a random index.
      load_golden();
      n = int'($urandom_range(0, 15));
      resp[n] = ~gold[n];
      run_sweep("single_fault", -1);
      check("single_fault_idx", first_err_idx, n);

      // Reset mid-sweep while abcd = 5.
      load_golden();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (abcd !== 4'd5 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("mid_reset_reached_5", abcd, 5);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
      run_sweep("after_reset", -1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/sweep_checker.md
# sweep_checker

Self-checking truth-table sweeper for a 4-input combinational function under test. On `start` it drives the 16 input combinations ABCD = 0000…1111 in ascending order. After each vector has settled it samples the function output and compares it against a parameterised expected truth table. It accumulates a mismatch count and reports pass/fail at the end of the sweep. It is the synthesizable stimulus/response stage wrapped around a gate-level function block such as F = ΠM(0,1,2,8,10,12,14).

## Interface

Parameters:
- `EXPECT_MASK`, default 16'hAAF8
  - Expected F per index; bit i = F(ABCD = i).
  - The default encodes ΠM(0,1,2,8,10,12,14).
- `SETTLE`, default 2
  - Cycles each vector is held before sampling.
  - Legal range 1–15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request to begin a sweep; sampled only in IDLE
- `f_in`  in  1  output F of the function under test
- `abcd`  out  4  vector driven to the function; abcd[3]=A … abcd[0]=D
- `busy`  out  1  high from the cycle after start until done
- `done`  out  1  one-cycle pulse when the sweep completes
- `pass`  out  1  high when the last completed sweep had zero mismatches; held until next start
- `err_count`  out  5  mismatches in current/last sweep, 0–16
- `err_valid`  out  1  at least one mismatch recorded
- `first_err_idx`  out  4  index of first mismatching vector; valid when err_valid

## Operation

- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: every output is 0 (abcd=0, busy=0, done=0, pass=0, err_count=0, err_valid=0, first_err_idx=0). State is IDLE, idx=0, settle counter=0.
- IDLE:
  - With start=1, go to SETTLE.
  - Clear idx, err_count, err_valid, first_err_idx and pass; set busy.
- SETTLE:
  - abcd=idx; counter increments each cycle.
  - When counter == SETTLE−1, go to SAMPLE.
- SAMPLE:
  - Compare f_in with EXPECT_MASK[idx].
  - On a mismatch: err_count+1, and if err_valid=0, set err_valid and latch first_err_idx=idx.
  - If idx==15, go to DONE. Otherwise idx+1, counter=0, go to SETTLE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - pass=1 if err_count==0. The compare made on the final SAMPLE counts.
  - Go to IDLE.
- start while busy (SETTLE/SAMPLE/DONE) is ignored; no queueing.
- idx does not wrap during a sweep; the sweep ends after index 15.
- err_count saturates naturally at 16; 5 bits suffice, so no overflow.
- Reset asserted mid-sweep aborts immediately to reset values. No partial pass/done is produced.

## Timing

- abcd changes on the clock edge that enters SETTLE.
- f_in is sampled on the SAMPLE cycle, SETTLE cycles after abcd changed.
- Per vector: SETTLE+1 cycles. Full sweep: 16·(SETTLE+1) cycles from the start-sampled edge to the done pulse. With the default this is 48.
- Results (pass, err_count, err_valid, first_err_idx) are stable from the done cycle until the next accepted start.
- Back-to-back: start in the cycle after done is accepted.

## Configuration

- `SWEEP_SYNC_EN`
  - Defined: f_in passes through a 2-flop synchronizer before compare.
  - The effective hold per vector becomes SETTLE+2 cycles, so that latency is absorbed. Sweep length is 16·(SETTLE+3) cycles.
  - Undefined: f_in is compared directly; timing is as above.

## Structure

- Shared package `sweep_pkg` contains:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE)
  - `VEC_COUNT`=16, `IDX_W`=4, `ERR_W`=5
  - the default mask constant `MASK_PIM_0_1_2_8_10_12_14`=16'hAAF8
- One sub-module, `sweep_sync`, the 2-flop synchronizer. It is instantiated only under `SWEEP_SYNC_EN`.

## Test plan

- Golden model of ΠM(0,1,2,8,10,12,14) on f_in, default params, pulse start → done at cycle 48, pass=1, err_count=0, err_valid=0.
- f_in tied 0 → err_count=9, err_valid=1, first_err_idx=3, pass=0.
- f_in tied 1 → err_count=7, first_err_idx=0, pass=0.
- start re-pulsed at cycle 10 of a sweep → ignored; done still at cycle 48 with unchanged results.
- rst asserted while abcd=5 → all outputs 0 immediately. A new start then completes a full 48-cycle sweep with pass=1.
- Build with `SWEEP_SYNC_EN`, golden model → done at cycle 80, pass=1.
